// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
//
// Shared definitions for the machine-mode trap/return sequencer:
//   - CSR addresses of the registers the sequencer touches
//   - mstatus bit positions
//   - sequencer state encoding
//   - mstatus update helpers for trap entry and mret
//
// The mstatus helpers operate on the low MST_LO_W bits only. Every field the
// sequencer modifies lives below bit 13, so callers splice the untouched upper
// bits back on. This keeps the helpers independent of XLEN.
// -----------------------------------------------------------------------------
package csr_pkg;

  // Machine-mode CSR addresses (12-bit CSR address space).
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mstatus bit positions.
  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  // Width of the mstatus slice the helpers rewrite (bits 12:0).
  localparam int MST_LO_W = MST_MPP_HI + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_EPC   = 3'd1,
    T_CAUSE = 3'd2,
    T_MST   = 3'd3,
    M_EPC   = 3'd4,
    M_MST   = 3'd5,
    DONE    = 3'd6
  } seq_state_t;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode, all else kept.
  function automatic logic [MST_LO_W-1:0] trap_mstatus_lo(
    input logic [MST_LO_W-1:0] mst
  );
    logic [MST_LO_W-1:0] res;
    res                        = mst;
    res[MST_MPIE]              = mst[MST_MIE];
    res[MST_MIE]               = 1'b0;
    res[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    return res;
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1, MPP <= M-mode, all else kept.
  function automatic logic [MST_LO_W-1:0] mret_mstatus_lo(
    input logic [MST_LO_W-1:0] mst
  );
    logic [MST_LO_W-1:0] res;
    res                        = mst;
    res[MST_MIE]               = mst[MST_MPIE];
    res[MST_MPIE]              = 1'b1;
    res[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    return res;
  endfunction

endpackage : csr_pkg

// File: rtl/csr_trap_seq.sv
// -----------------------------------------------------------------------------
// csr_trap_seq
//
// Trap/return sequencer in front of the machine-mode CSR file. It owns the
// CSR file's single read port and single write port.
//
// In IDLE the core's CSR-instruction traffic passes straight through. A trap
// request saves mepc, mcause and mstatus over three cycles, fetches mtvec and
// issues a PC redirect. An mret request restores mstatus and redirects to mepc.
// While a sequence runs, busy stalls the core: its writes are dropped and its
// read data reads as zero.
//
// Parameters:
//   XLEN  data / PC width
//   AW    CSR address width
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   trap_req/_cause/_pc        trap request pulse, mcause value, faulting PC
//   mret_req                   mret request pulse
//   busy                       sequence in progress
//   trap_ack                   one-cycle pulse, trap sequence complete
//   redirect_valid/_pc         one-cycle redirect pulse and target PC
//   core_csr_*, core_*_addr,
//   core_wr_dat, core_rd_dat   core-side CSR port
//   csr_rd/_wr, csr_*_addr,
//   csr_wr_dat, csr_rd_dat     CSR-file port (combinational read)
//
// Build option:
//   CSR_VECTORED_EN  when defined, interrupts taken with mtvec[1:0]==2'b01 jump
//                    to base + 4*cause; otherwise every trap uses the base.
// -----------------------------------------------------------------------------
module csr_trap_seq
  import csr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 12
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_req,

  output logic            busy,
  output logic            trap_ack,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,

  input  logic            core_csr_rd,
  input  logic            core_csr_wr,
  input  logic [AW-1:0]   core_rd_addr,
  input  logic [AW-1:0]   core_wr_addr,
  input  logic [XLEN-1:0] core_wr_dat,
  output logic [XLEN-1:0] core_rd_dat,

  output logic            csr_rd,
  output logic            csr_wr,
  output logic [AW-1:0]   csr_rd_addr,
  output logic [AW-1:0]   csr_wr_addr,
  output logic [XLEN-1:0] csr_wr_dat,
  input  logic [XLEN-1:0] csr_rd_dat
);

  localparam logic [AW-1:0] A_MSTATUS = AW'(CSR_MSTATUS);
  localparam logic [AW-1:0] A_MTVEC   = AW'(CSR_MTVEC);
  localparam logic [AW-1:0] A_MEPC    = AW'(CSR_MEPC);
  localparam logic [AW-1:0] A_MCAUSE  = AW'(CSR_MCAUSE);

  seq_state_t      state_q, state_d;
  logic            is_trap_q, is_trap_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mst_q, mst_d;
  logic [XLEN-1:0] tvec_q, tvec_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] redir_q, redir_d;

  logic [XLEN-1:0] trap_mst_wr;
  logic [XLEN-1:0] mret_mst_wr;
  logic [XLEN-1:0] tvec_capture;
  logic [XLEN-1:0] trap_target;

  // New mstatus values: only the low bits change, the rest are carried over.
  assign trap_mst_wr = {mst_q[XLEN-1:MST_LO_W],
                        trap_mstatus_lo(mst_q[MST_LO_W-1:0])};
  // During M_MST the read and write of mstatus happen in the same cycle, so the
  // restored value is built straight from the combinational read data.
  assign mret_mst_wr = {csr_rd_dat[XLEN-1:MST_LO_W],
                        mret_mstatus_lo(csr_rd_dat[MST_LO_W-1:0])};

`ifdef CSR_VECTORED_EN
  logic [XLEN-1:0] tvec_base;

  assign tvec_capture = csr_rd_dat;
  assign tvec_base    = {tvec_q[XLEN-1:2], 2'b00};

  // Vectored mode applies to interrupts only; exceptions go to the base.
  always_comb begin
    trap_target = tvec_base;
    if (tvec_q[1:0] == 2'b01 && cause_q[XLEN-1]) begin
      trap_target = tvec_base + {cause_q[XLEN-3:0], 2'b00};
    end
  end
`else
  // Direct mode only: the mode bits are cleared on capture so the stored
  // value is already the aligned target.
  assign tvec_capture = {csr_rd_dat[XLEN-1:2], 2'b00};
  assign trap_target  = tvec_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    is_trap_d      = is_trap_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    mst_d          = mst_q;
    tvec_d         = tvec_q;
    epc_d          = epc_q;
    redir_d        = redir_q;

    busy           = 1'b1;
    trap_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = redir_q;
    core_rd_dat    = '0;

    csr_rd         = 1'b0;
    csr_wr         = 1'b0;
    csr_rd_addr    = '0;
    csr_wr_addr    = '0;
    csr_wr_dat     = '0;

    unique case (state_q)
      IDLE: begin
        busy        = 1'b0;
        csr_rd      = core_csr_rd;
        csr_wr      = core_csr_wr;
        csr_rd_addr = core_rd_addr;
        csr_wr_addr = core_wr_addr;
        csr_wr_dat  = core_wr_dat;
        core_rd_dat = csr_rd_dat;

        // The instruction that raised the request must not commit its write;
        // its read still completes.
        if (trap_req) begin
          csr_wr    = 1'b0;
          is_trap_d = 1'b1;
          cause_d   = trap_cause;
          pc_d      = {trap_pc[XLEN-1:2], 2'b00};
          state_d   = T_EPC;
        end else if (mret_req) begin
          csr_wr    = 1'b0;
          is_trap_d = 1'b0;
          state_d   = M_EPC;
        end
      end

      T_EPC: begin
        csr_wr      = 1'b1;
        csr_wr_addr = A_MEPC;
        csr_wr_dat  = pc_q;
        csr_rd      = 1'b1;
        csr_rd_addr = A_MSTATUS;
        mst_d       = csr_rd_dat;
        state_d     = T_CAUSE;
      end

      T_CAUSE: begin
        csr_wr      = 1'b1;
        csr_wr_addr = A_MCAUSE;
        csr_wr_dat  = cause_q;
        csr_rd      = 1'b1;
        csr_rd_addr = A_MTVEC;
        tvec_d      = tvec_capture;
        state_d     = T_MST;
      end

      T_MST: begin
        csr_wr      = 1'b1;
        csr_wr_addr = A_MSTATUS;
        csr_wr_dat  = trap_mst_wr;
        state_d     = DONE;
      end

      M_EPC: begin
        csr_rd      = 1'b1;
        csr_rd_addr = A_MEPC;
        epc_d       = csr_rd_dat;
        state_d     = M_MST;
      end

      M_MST: begin
        csr_rd      = 1'b1;
        csr_rd_addr = A_MSTATUS;
        csr_wr      = 1'b1;
        csr_wr_addr = A_MSTATUS;
        csr_wr_dat  = mret_mst_wr;
        state_d     = DONE;
      end

      DONE: begin
        redirect_valid = 1'b1;
        trap_ack       = is_trap_q;
        redirect_pc    = is_trap_q ? trap_target : epc_q;
        redir_d        = redirect_pc;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      is_trap_q <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      mst_q     <= '0;
      tvec_q    <= '0;
      epc_q     <= '0;
      redir_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q   <= state_d;
      is_trap_q <= is_trap_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      mst_q     <= mst_d;
      tvec_q    <= tvec_d;
      epc_q     <= epc_d;
      redir_q   <= redir_d;
    end
  end

  // A new request while a sequence is running would be silently dropped.
  a_no_req_while_busy : assert property (
    @(posedge clk) disable iff (!reset) busy |-> !(trap_req || mret_req)
  );

endmodule : csr_trap_seq

// File: tb/tb_csr_trap_seq.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_seq
//
// Bench for csr_trap_seq. A small CSR file (array + combinational read) sits on
// the CSR port; it is loaded through the core pass-through path. Expected CSR
// contents, redirect targets and latencies come from a behavioural model of the
// trap/mret rules, written directly in terms of mstatus bit arithmetic.
// -----------------------------------------------------------------------------
module tb_csr_trap_seq;

  localparam int XLEN = 32;
  localparam int AW   = 12;

  localparam logic [AW-1:0] A_MSTATUS = 12'h300;
  localparam logic [AW-1:0] A_MTVEC   = 12'h305;
  localparam logic [AW-1:0] A_MSCRATCH = 12'h340;
  localparam logic [AW-1:0] A_MEPC    = 12'h341;
  localparam logic [AW-1:0] A_MCAUSE  = 12'h342;

  logic            clk = 1'b0;
  logic            reset;
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret_req;
  logic            busy;
  logic            trap_ack;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            core_csr_rd;
  logic            core_csr_wr;
  logic [AW-1:0]   core_rd_addr;
  logic [AW-1:0]   core_wr_addr;
  logic [XLEN-1:0] core_wr_dat;
  logic [XLEN-1:0] core_rd_dat;
  logic            csr_rd;
  logic            csr_wr;
  logic [AW-1:0]   csr_rd_addr;
  logic [AW-1:0]   csr_wr_addr;
  logic [XLEN-1:0] csr_wr_dat;
  logic [XLEN-1:0] csr_rd_dat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csr_trap_seq #(.XLEN(XLEN), .AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret_req       (mret_req),
    .busy           (busy),
    .trap_ack       (trap_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .core_csr_rd    (core_csr_rd),
    .core_csr_wr    (core_csr_wr),
    .core_rd_addr   (core_rd_addr),
    .core_wr_addr   (core_wr_addr),
    .core_wr_dat    (core_wr_dat),
    .core_rd_dat    (core_rd_dat),
    .csr_rd         (csr_rd),
    .csr_wr         (csr_wr),
    .csr_rd_addr    (csr_rd_addr),
    .csr_wr_addr    (csr_wr_addr),
    .csr_wr_dat     (csr_wr_dat),
    .csr_rd_dat     (csr_rd_dat)
  );

  // CSR file: combinational read, write on the rising edge.
  logic [XLEN-1:0] mem [4096];
  assign csr_rd_dat = csr_rd ? mem[csr_rd_addr] : '0;
  always @(posedge clk) if (csr_wr) mem[csr_wr_addr] <= csr_wr_dat;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] m_trap_mst(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] m_mret_mst(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1880 | (m[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] m_trap_target(input logic [31:0] tvec,
                                                input logic [31:0] cause);
    logic [31:0] base;
    base = tvec & ~32'h3;
`ifdef CSR_VECTORED_EN
    if (tvec[1:0] == 2'b01 && cause[31]) return base + (cause & 32'h7FFF_FFFF) * 4;
`endif
    return base;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write a CSR through the idle pass-through path.
  task automatic poke(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    core_csr_wr  = 1'b1;
    core_wr_addr = a;
    core_wr_dat  = d;
    tick();
    core_csr_wr  = 1'b0;
  endtask

  // Pulse the requests and wait for the redirect; lat = -1 on timeout.
  task automatic run_seq(input bit t, input bit m, output int lat,
                         output bit ack, output logic [XLEN-1:0] pc);
    trap_req = t;
    mret_req = m;
    lat = 0;
    ack = 1'b0;
    pc  = '0;
    forever begin
      tick();
      lat++;
      trap_req = 1'b0;
      mret_req = 1'b0;
      if (redirect_valid) begin
        ack = trap_ack;
        pc  = redirect_pc;
        break;
      end
      if (lat >= 16) begin
        lat = -1;
        break;
      end
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    trap_req = 1'b0; mret_req = 1'b0;
    trap_cause = '0; trap_pc = '0;
    core_csr_rd = 1'b0; core_csr_wr = 1'b0;
    core_rd_addr = '0; core_wr_addr = '0; core_wr_dat = '0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
    n_checks++; if (trap_ack !== 1'b0) begin n_fail++; $display("FAIL reset_trap_ack: got %b expected 0", trap_ack); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    n_checks++; if (csr_wr !== 1'b0) begin n_fail++; $display("FAIL reset_csr_wr: got %b expected 0", csr_wr); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat; bit ack; logic [XLEN-1:0] pc;
    poke(A_MTVEC, 32'h0000_0100);
    poke(A_MSTATUS, 32'h0000_0008);
    trap_cause = 32'd2;
    trap_pc    = 32'h0000_2003;
    run_seq(1'b1, 1'b0, lat, ack, pc);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_trap_latency: got %0d expected 4", lat); end
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL basic_trap_ack: got %b expected 1", ack); end
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL basic_trap_pc: got %h expected 100", pc); end
    n_checks++; if (mem[A_MEPC] !== 32'h2000) begin n_fail++; $display("FAIL basic_mepc: got %h expected 2000", mem[A_MEPC]); end
    n_checks++; if (mem[A_MCAUSE] !== 32'h2) begin n_fail++; $display("FAIL basic_mcause: got %h expected 2", mem[A_MCAUSE]); end
    n_checks++; if (mem[A_MSTATUS] !== 32'h1880) begin n_fail++; $display("FAIL basic_trap_mstatus: got %h expected 1880", mem[A_MSTATUS]); end
    n_checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after_done: redirect_valid=%b busy=%b expected 0 0", redirect_valid, busy); end
    n_checks++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL basic_redirect_hold: got %h expected 100", redirect_pc); end

    run_seq(1'b0, 1'b1, lat, ack, pc);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_mret_latency: got %0d expected 3", lat); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL basic_mret_ack: got %b expected 0", ack); end
    n_checks++; if (pc !== 32'h2000) begin n_fail++; $display("FAIL basic_mret_pc: got %h expected 2000", pc); end
    n_checks++; if (mem[A_MSTATUS] !== 32'h1888) begin n_fail++; $display("FAIL basic_mret_mstatus: got %h expected 1888", mem[A_MSTATUS]); end
  endtask

  task automatic test_simultaneous();
    int lat; bit ack; logic [XLEN-1:0] pc;
    poke(A_MSCRATCH, 32'h0000_0055);
    poke(A_MTVEC, 32'h0000_0200);
    poke(A_MSTATUS, 32'h0000_0000);
    trap_cause   = 32'd11;
    trap_pc      = 32'h0000_3000;
    core_csr_wr  = 1'b1;
    core_wr_addr = A_MSCRATCH;
    core_wr_dat  = 32'hDEAD_BEEF;
    trap_req = 1'b1;
    mret_req = 1'b1;
    #1;
    n_checks++; if (csr_wr !== 1'b0) begin n_fail++; $display("FAIL simul_wr_suppressed: got %b expected 0", csr_wr); end
    run_seq(1'b1, 1'b1, lat, ack, pc);
    core_csr_wr = 1'b0;
    n_checks++; if (lat !== 4 || ack !== 1'b1) begin n_fail++; $display("FAIL simul_trap_taken: lat=%0d ack=%b expected 4 1", lat, ack); end
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL simul_pc: got %h expected 200", pc); end
    n_checks++; if (mem[A_MEPC] !== 32'h3000) begin n_fail++; $display("FAIL simul_mepc: got %h expected 3000", mem[A_MEPC]); end
    n_checks++; if (mem[A_MSCRATCH] !== 32'h55) begin n_fail++; $display("FAIL simul_core_write_dropped: got %h expected 55", mem[A_MSCRATCH]); end
  endtask

  task automatic test_busy_passthrough();
    poke(A_MSCRATCH, 32'h0000_0077);
    trap_cause   = 32'd3;
    trap_pc      = 32'h0000_4000;
    trap_req     = 1'b1;
    tick();
    trap_req     = 1'b0;
    core_csr_wr  = 1'b1;
    core_wr_addr = A_MSCRATCH;
    core_wr_dat  = 32'h0000_1234;
    core_csr_rd  = 1'b1;
    core_rd_addr = A_MSCRATCH;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag cycle %0d: got %b expected 1", c, busy); end
      n_checks++; if (core_rd_dat !== 32'h0) begin n_fail++; $display("FAIL busy_rd_dat cycle %0d: got %h expected 0", c, core_rd_dat); end
      if (c < 4) tick();
    end
    tick();
    core_csr_wr = 1'b0;
    core_csr_rd = 1'b0;
    n_checks++; if (mem[A_MSCRATCH] !== 32'h77) begin n_fail++; $display("FAIL busy_write_dropped: got %h expected 77", mem[A_MSCRATCH]); end

    core_csr_wr  = 1'b1;
    core_wr_addr = A_MSCRATCH;
    core_wr_dat  = 32'h0000_ABCD;
    #1;
    n_checks++; if (csr_wr !== 1'b1 || csr_wr_addr !== A_MSCRATCH || csr_wr_dat !== 32'hABCD) begin
      n_fail++; $display("FAIL idle_wr_passthrough: wr=%b addr=%h dat=%h expected 1 340 abcd", csr_wr, csr_wr_addr, csr_wr_dat);
    end
    tick();
    core_csr_wr  = 1'b0;
    core_csr_rd  = 1'b1;
    core_rd_addr = A_MSCRATCH;
    #1;
    n_checks++; if (mem[A_MSCRATCH] !== 32'hABCD) begin n_fail++; $display("FAIL idle_write_landed: got %h expected abcd", mem[A_MSCRATCH]); end
    n_checks++; if (core_rd_dat !== 32'hABCD) begin n_fail++; $display("FAIL idle_rd_passthrough: got %h expected abcd", core_rd_dat); end
    core_csr_rd = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    poke(A_MEPC, 32'h0000_0111);
    poke(A_MCAUSE, 32'h0000_0222);
    poke(A_MTVEC, 32'h0000_0400);
    trap_cause = 32'd5;
    trap_pc    = 32'h0000_4444;
    trap_req   = 1'b1;
    tick();
    trap_req   = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_immediate: busy=%b redirect_valid=%b expected 0 0", busy, redirect_valid); end
    tick();
    n_checks++; if (mem[A_MEPC] !== 32'h4444) begin n_fail++; $display("FAIL midrst_mepc: got %h expected 4444", mem[A_MEPC]); end
    n_checks++; if (mem[A_MCAUSE] !== 32'h222) begin n_fail++; $display("FAIL midrst_mcause: got %h expected 222", mem[A_MCAUSE]); end
    n_checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_redirect: valid=%b pc=%h expected 0 0", redirect_valid, redirect_pc); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_vectored();
    int lat; bit ack; logic [XLEN-1:0] pc; logic [XLEN-1:0] exp_pc;
`ifdef CSR_VECTORED_EN
    exp_pc = 32'h0000_011C;
`else
    exp_pc = 32'h0000_0100;
`endif
    poke(A_MTVEC, 32'h0000_0101);
    trap_cause = 32'h8000_0007;
    trap_pc    = 32'h0000_5000;
    run_seq(1'b1, 1'b0, lat, ack, pc);
    n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL vectored_irq_pc: got %h expected %h", pc, exp_pc); end
    trap_cause = 32'h0000_0007;
    run_seq(1'b1, 1'b0, lat, ack, pc);
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL vectored_exc_pc: got %h expected 100", pc); end
  endtask

  task automatic test_random();
    int lat; bit ack; logic [XLEN-1:0] pc;
    logic [31:0] mst, tvec, cause, tpc, epc, exp_mst;
    logic [1:0]  mode;
    for (int i = 0; i < 24; i++) begin
      mst   = $urandom;
      tvec  = $urandom;
      mode  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom);
      tvec  = (tvec & ~32'h3) | {30'h0, mode};
      cause = $urandom;
      tpc   = $urandom;
      poke(A_MTVEC, tvec);
      poke(A_MSTATUS, mst);
      trap_cause = cause;
      trap_pc    = tpc;
      run_seq(1'b1, 1'b0, lat, ack, pc);
      exp_mst = m_trap_mst(mst);
      n_checks++; if (lat !== 4 || ack !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_trap_timing: lat=%0d ack=%b expected 4 1", i, lat, ack); end
      n_checks++; if (pc !== m_trap_target(tvec, cause)) begin n_fail++; $display("FAIL rnd%0d_trap_pc: got %h expected %h", i, pc, m_trap_target(tvec, cause)); end
      n_checks++; if (mem[A_MEPC] !== (tpc & ~32'h3)) begin n_fail++; $display("FAIL rnd%0d_mepc: got %h expected %h", i, mem[A_MEPC], tpc & ~32'h3); end
      n_checks++; if (mem[A_MCAUSE] !== cause) begin n_fail++; $display("FAIL rnd%0d_mcause: got %h expected %h", i, mem[A_MCAUSE], cause); end
      n_checks++; if (mem[A_MSTATUS] !== exp_mst) begin n_fail++; $display("FAIL rnd%0d_trap_mstatus: got %h expected %h", i, mem[A_MSTATUS], exp_mst); end

      epc = $urandom;
      poke(A_MEPC, epc);
      run_seq(1'b0, 1'b1, lat, ack, pc);
      n_checks++; if (lat !== 3 || ack !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_mret_timing: lat=%0d ack=%b expected 3 0", i, lat, ack); end
      n_checks++; if (pc !== epc) begin n_fail++; $display("FAIL rnd%0d_mret_pc: got %h expected %h", i, pc, epc); end
      n_checks++; if (mem[A_MSTATUS] !== m_mret_mst(exp_mst)) begin n_fail++; $display("FAIL rnd%0d_mret_mstatus: got %h expected %h", i, mem[A_MSTATUS], m_mret_mst(exp_mst)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_busy_passthrough();
    test_reset_mid();
    test_vectored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule : tb_csr_trap_seq
